// File: rtl/vta_mem_pkg.sv
// Shared opcode encodings, FSM state type and pointer-wrap helper for the VTA memory arbiter.
// No logic of its own; imported by the arbiter top and its round-robin picker.
package vta_mem_pkg;

  localparam logic MEM_OP_RD = 1'b0;
  localparam logic MEM_OP_WR = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RD,
    WR
  } state_t;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/vta_rr_arbiter.sv
// Round-robin picker: first asserted req at or after ptr, wrapping modulo N.
// Purely combinational, zero latency; no backpressure (the caller decides when to sample).
module vta_rr_arbiter #(
  parameter int N = 4,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         gnt_valid,
  output logic [W-1:0] gnt_idx
);

  // Scan from farthest to nearest so the candidate closest to ptr is written last and wins.
  always_comb begin
    int idx;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = W'(idx);
      end
    end
  end

endmodule

// File: rtl/vta_mem_arbiter.sv
// Shares one VTAMemDPI-style port among NUM_CH clients, one burst at a time, round-robin grant.
// Request issue 1 cycle after grant; data beats pass through combinationally, stalled by the granted client.
module vta_mem_arbiter
  import vta_mem_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int MEM_LEN_BITS  = 8,
  parameter int MEM_ADDR_BITS = 64,
  parameter int MEM_DATA_BITS = 64,
  localparam int CH_BITS      = $clog2(NUM_CH)
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic [NUM_CH-1:0]                 c_req_valid,
  output logic [NUM_CH-1:0]                 c_req_ready,
  input  logic [NUM_CH-1:0]                 c_req_opcode,
  input  logic [NUM_CH*MEM_LEN_BITS-1:0]    c_req_len,
  input  logic [NUM_CH*MEM_ADDR_BITS-1:0]   c_req_addr,
  input  logic [NUM_CH-1:0]                 c_wr_valid,
  output logic [NUM_CH-1:0]                 c_wr_ready,
  input  logic [NUM_CH*MEM_DATA_BITS-1:0]   c_wr_bits,
  output logic [NUM_CH-1:0]                 c_rd_valid,
  output logic [MEM_DATA_BITS-1:0]          c_rd_bits,
  input  logic [NUM_CH-1:0]                 c_rd_ready,
  output logic                              mem_req_valid,
  output logic                              mem_req_opcode,
  output logic [MEM_LEN_BITS-1:0]           mem_req_len,
  output logic [MEM_ADDR_BITS-1:0]          mem_req_addr,
  output logic                              mem_wr_valid,
  output logic [MEM_DATA_BITS-1:0]          mem_wr_bits,
  input  logic                              mem_rd_valid,
  input  logic [MEM_DATA_BITS-1:0]          mem_rd_bits,
  output logic                              mem_rd_ready,
  output logic                              busy,
  output logic [CH_BITS-1:0]                grant_id
);

  state_t                     state;
  logic [CH_BITS-1:0]         rr_ptr;
  logic                       opcode_q;
  logic [MEM_ADDR_BITS-1:0]   addr_q;
  logic [MEM_LEN_BITS-1:0]    beat_cnt;

  logic                       arb_vld;
  logic [CH_BITS-1:0]         arb_idx;
  logic                       rd_beat;
  logic                       wr_beat;

  vta_rr_arbiter #(.N(NUM_CH)) u_rr (
    .req       (c_req_valid),
    .ptr       (rr_ptr),
    .gnt_valid (arb_vld),
    .gnt_idx   (arb_idx)
  );

  assign rd_beat = (state == RD) && mem_rd_valid && c_rd_ready[grant_id];
  assign wr_beat = (state == WR) && c_wr_valid[grant_id];
  assign busy    = (state != IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      opcode_q <= MEM_OP_RD;
      addr_q   <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_vld) begin
            grant_id <= arb_idx;
            opcode_q <= c_req_opcode[arb_idx];
            addr_q   <= c_req_addr[int'(arb_idx)*MEM_ADDR_BITS +: MEM_ADDR_BITS];
            beat_cnt <= c_req_len[int'(arb_idx)*MEM_LEN_BITS +: MEM_LEN_BITS];
            state    <= ISSUE;
          end
        end
        ISSUE: state <= (opcode_q == MEM_OP_WR) ? WR : RD;
        RD, WR: begin
          if (rd_beat || wr_beat) begin
            if (beat_cnt == '0) begin
              state  <= IDLE;
              rr_ptr <= CH_BITS'(wrap_inc(int'(grant_id), NUM_CH));
            end else begin
              beat_cnt <= beat_cnt - MEM_LEN_BITS'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    c_req_ready    = '0;
    c_wr_ready     = '0;
    c_rd_valid     = '0;
    c_rd_bits      = '0;
    mem_req_valid  = 1'b0;
    mem_req_opcode = 1'b0;
    mem_req_len    = '0;
    mem_req_addr   = '0;
    mem_wr_valid   = 1'b0;
    mem_wr_bits    = '0;
    mem_rd_ready   = 1'b0;
    case (state)
      ISSUE: begin
        // beat_cnt has not been decremented yet, so it still holds the requested len.
        mem_req_valid         = 1'b1;
        mem_req_opcode        = opcode_q;
        mem_req_len           = beat_cnt;
        mem_req_addr          = addr_q;
        c_req_ready[grant_id] = 1'b1;
      end
      RD: begin
        mem_rd_ready         = c_rd_ready[grant_id];
        c_rd_valid[grant_id] = mem_rd_valid;
        c_rd_bits            = mem_rd_bits;
      end
      WR: begin
        c_wr_ready[grant_id] = 1'b1;
        mem_wr_valid         = c_wr_valid[grant_id];
        mem_wr_bits          = c_wr_bits[int'(grant_id)*MEM_DATA_BITS +: MEM_DATA_BITS];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_vta_mem_arbiter.sv
// Directed bench for vta_mem_arbiter: the bench plays both the clients and the memory DPI.
module tb_vta_mem_arbiter;

  localparam int NCH = 4;
  localparam int LB  = 8;
  localparam int AB  = 64;
  localparam int DB  = 64;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic              reset_n;
  logic [NCH-1:0]    c_req_valid, c_req_ready, c_req_opcode;
  logic [NCH*LB-1:0] c_req_len;
  logic [NCH*AB-1:0] c_req_addr;
  logic [NCH-1:0]    c_wr_valid, c_wr_ready;
  logic [NCH*DB-1:0] c_wr_bits;
  logic [NCH-1:0]    c_rd_valid, c_rd_ready;
  logic [DB-1:0]     c_rd_bits;
  logic              mem_req_valid, mem_req_opcode;
  logic [LB-1:0]     mem_req_len;
  logic [AB-1:0]     mem_req_addr;
  logic              mem_wr_valid;
  logic [DB-1:0]     mem_wr_bits;
  logic              mem_rd_valid;
  logic [DB-1:0]     mem_rd_bits;
  logic              mem_rd_ready;
  logic              busy;
  logic [1:0]        grant_id;

  int checks = 0;
  int errors = 0;

  vta_mem_arbiter #(
    .NUM_CH(NCH), .MEM_LEN_BITS(LB), .MEM_ADDR_BITS(AB), .MEM_DATA_BITS(DB)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .c_req_valid(c_req_valid), .c_req_ready(c_req_ready), .c_req_opcode(c_req_opcode),
    .c_req_len(c_req_len), .c_req_addr(c_req_addr),
    .c_wr_valid(c_wr_valid), .c_wr_ready(c_wr_ready), .c_wr_bits(c_wr_bits),
    .c_rd_valid(c_rd_valid), .c_rd_bits(c_rd_bits), .c_rd_ready(c_rd_ready),
    .mem_req_valid(mem_req_valid), .mem_req_opcode(mem_req_opcode),
    .mem_req_len(mem_req_len), .mem_req_addr(mem_req_addr),
    .mem_wr_valid(mem_wr_valid), .mem_wr_bits(mem_wr_bits),
    .mem_rd_valid(mem_rd_valid), .mem_rd_bits(mem_rd_bits), .mem_rd_ready(mem_rd_ready),
    .busy(busy), .grant_id(grant_id)
  );

  task automatic clear_inputs();
    c_req_valid = '0; c_req_opcode = '0; c_req_len = '0; c_req_addr = '0;
    c_wr_valid = '0; c_wr_bits = '0; c_rd_ready = '0;
    mem_rd_valid = 1'b0; mem_rd_bits = '0;
  endtask

  task automatic set_req(input int ch, input bit op, input int len, input logic [63:0] addr);
    c_req_valid[ch] = 1'b1;
    c_req_opcode[ch] = op;
    c_req_len[ch*LB +: LB] = LB'(len);
    c_req_addr[ch*AB +: AB] = addr;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    clear_inputs();
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Returns at the negedge (+1) where mem_req_valid is first seen, or ok=0 after 20 cycles.
  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock); #1;
      if (mem_req_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic serve_read_beat();
    @(negedge clock);
    mem_rd_valid = 1'b1; c_rd_ready = '1; mem_rd_bits = 64'hBEEF;
    @(negedge clock);
    mem_rd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clear_inputs();
    mem_rd_valid = 1'b1; mem_rd_bits = 64'h1234; c_rd_ready = '1;
    repeat (3) @(negedge clock);
    #1;
    checks++; if (busy !== 1'b0 || grant_id !== 2'd0) begin errors++;
      $display("FAIL reset_state busy=%0b grant_id=%0d expected 0/0", busy, grant_id); end
    checks++; if (mem_req_valid !== 1'b0 || mem_wr_valid !== 1'b0 || mem_rd_ready !== 1'b0) begin errors++;
      $display("FAIL reset_mem req=%0b wr=%0b rd_ready=%0b expected 0", mem_req_valid, mem_wr_valid, mem_rd_ready); end
    checks++; if (c_req_ready !== 4'h0 || c_wr_ready !== 4'h0 || c_rd_valid !== 4'h0 || c_rd_bits !== 64'h0) begin errors++;
      $display("FAIL reset_client req_rdy=%h wr_rdy=%h rd_vld=%h rd_bits=%h expected 0", c_req_ready, c_wr_ready, c_rd_valid, c_rd_bits); end
    clear_inputs();
    reset_n = 1'b1;
    @(negedge clock); #1;
    checks++; if (busy !== 1'b0 || mem_req_valid !== 1'b0) begin errors++;
      $display("FAIL reset_idle busy=%0b req=%0b expected 0/0", busy, mem_req_valid); end
  endtask

  task automatic test_single_read();
    bit ok;
    @(negedge clock);
    set_req(0, 1'b0, 3, 64'h100);
    wait_req(ok);
    checks++; if (!ok || mem_req_opcode !== 1'b0 || mem_req_len !== 8'd3 || mem_req_addr !== 64'h100 || c_req_ready !== 4'b0001) begin errors++;
      $display("FAIL t1_issue ok=%0b op=%0b len=%0d addr=%h req_rdy=%b expected 1/0/3/100/0001", ok, mem_req_opcode, mem_req_len, mem_req_addr, c_req_ready); end
    c_req_valid[0] = 1'b0;
    for (int b = 0; b < 4; b++) begin
      @(negedge clock);
      mem_rd_valid = 1'b1; mem_rd_bits = 64'hD000 + 64'(b); c_rd_ready = 4'b1111;
      #1;
      checks++; if (c_rd_valid !== 4'b0001 || c_rd_bits !== 64'hD000 + 64'(b) || mem_rd_ready !== 1'b1 || mem_req_valid !== 1'b0 || busy !== 1'b1) begin errors++;
        $display("FAIL t1_beat%0d rd_vld=%b bits=%h rdy=%0b req=%0b busy=%0b expected 0001/%h/1/0/1", b, c_rd_valid, c_rd_bits, mem_rd_ready, mem_req_valid, busy, 64'hD000 + 64'(b)); end
    end
    @(negedge clock);
    mem_rd_valid = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || c_rd_valid !== 4'b0000) begin errors++;
      $display("FAIL t1_done busy=%0b rd_vld=%b expected 0/0000", busy, c_rd_valid); end
    // rr_ptr should now be 1: with ch0 and ch1 both pending, ch1 wins first.
    set_req(0, 1'b0, 0, 64'h200);
    set_req(1, 1'b0, 0, 64'h300);
    wait_req(ok);
    checks++; if (!ok || grant_id !== 2'd1 || mem_req_addr !== 64'h300 || c_req_ready !== 4'b0010) begin errors++;
      $display("FAIL t1_rrptr ok=%0b grant=%0d addr=%h req_rdy=%b expected 1/1/300/0010", ok, grant_id, mem_req_addr, c_req_ready); end
    c_req_valid[1] = 1'b0;
    serve_read_beat();
    wait_req(ok);
    checks++; if (!ok || grant_id !== 2'd0 || mem_req_addr !== 64'h200) begin errors++;
      $display("FAIL t1_next ok=%0b grant=%0d addr=%h expected 1/0/200", ok, grant_id, mem_req_addr); end
    c_req_valid[0] = 1'b0;
    serve_read_beat();
  endtask

  task automatic test_round_robin();
    bit ok;
    int order[5] = '{0, 1, 2, 3, 0};
    logic [63:0] exp_addr;
    apply_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 0, 64'h1000 + 64'(i * 16));
    for (int n = 0; n < 5; n++) begin
      wait_req(ok);
      exp_addr = (n == 4) ? 64'h400 : 64'h1000 + 64'(order[n] * 16);
      checks++; if (!ok || grant_id !== 2'(order[n]) || c_req_ready !== 4'(1 << order[n]) || mem_req_addr !== exp_addr || mem_req_len !== 8'd0) begin errors++;
        $display("FAIL t2_grant%0d ok=%0b grant=%0d req_rdy=%b addr=%h len=%0d expected ch%0d addr=%h len=0", n, ok, grant_id, c_req_ready, mem_req_addr, mem_req_len, order[n], exp_addr); end
      // ch0 re-requests straight away with a new address; it must wait behind 1,2,3.
      if (n == 0) c_req_addr[0 +: AB] = 64'h400;
      else c_req_valid[order[n]] = 1'b0;
      serve_read_beat();
    end
  endtask

  task automatic test_write_gaps();
    bit ok;
    bit wv[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [63:0] wd[4] = '{64'hFFFF, 64'hA5, 64'hFFFF, 64'h5A};
    @(negedge clock);
    set_req(2, 1'b1, 1, 64'h2000);
    c_wr_valid[1] = 1'b1; c_wr_bits[1*DB +: DB] = 64'hDEAD;
    wait_req(ok);
    checks++; if (!ok || mem_req_opcode !== 1'b1 || mem_req_len !== 8'd1 || grant_id !== 2'd2 || c_req_ready !== 4'b0100) begin errors++;
      $display("FAIL t3_issue ok=%0b op=%0b len=%0d grant=%0d req_rdy=%b expected 1/1/1/2/0100", ok, mem_req_opcode, mem_req_len, grant_id, c_req_ready); end
    c_req_valid[2] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      c_wr_valid[2] = wv[k]; c_wr_bits[2*DB +: DB] = wd[k];
      #1;
      checks++; if (c_wr_ready !== 4'b0100 || mem_wr_valid !== wv[k] || (wv[k] && mem_wr_bits !== wd[k]) || busy !== 1'b1) begin errors++;
        $display("FAIL t3_cycle%0d wr_rdy=%b wr_vld=%0b bits=%h busy=%0b expected 0100/%0b/%h/1", k, c_wr_ready, mem_wr_valid, mem_wr_bits, busy, wv[k], wd[k]); end
    end
    @(negedge clock);
    c_wr_valid[2] = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || c_wr_ready !== 4'b0000 || mem_wr_valid !== 1'b0) begin errors++;
      $display("FAIL t3_done busy=%0b wr_rdy=%b wr_vld=%0b expected 0/0000/0", busy, c_wr_ready, mem_wr_valid); end
    clear_inputs();
  endtask

  task automatic test_rd_backpressure();
    bit ok;
    bit rdy[3] = '{1'b1, 1'b0, 1'b1};
    int beat_idx = 0;
    int got = 0;
    @(negedge clock);
    set_req(3, 1'b0, 1, 64'h3000);
    wait_req(ok);
    checks++; if (!ok || grant_id !== 2'd3) begin errors++;
      $display("FAIL t4_issue ok=%0b grant=%0d expected 1/3", ok, grant_id); end
    c_req_valid[3] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      mem_rd_valid = 1'b1; mem_rd_bits = 64'hE000 + 64'(beat_idx);
      c_rd_ready = rdy[k] ? 4'b1000 : 4'b0111;
      #1;
      checks++; if (mem_rd_ready !== rdy[k] || c_rd_valid !== 4'b1000 || c_rd_bits !== 64'hE000 + 64'(beat_idx) || busy !== 1'b1) begin errors++;
        $display("FAIL t4_cycle%0d rd_rdy=%0b rd_vld=%b bits=%h busy=%0b expected %0b/1000/%h/1", k, mem_rd_ready, c_rd_valid, c_rd_bits, busy, rdy[k], 64'hE000 + 64'(beat_idx)); end
      if (c_rd_valid[3] && c_rd_ready[3]) got++;
      if (rdy[k]) beat_idx++;
    end
    @(negedge clock);
    mem_rd_valid = 1'b1; c_rd_ready = 4'b1111;
    #1;
    checks++; if (busy !== 1'b0 || mem_rd_ready !== 1'b0 || c_rd_valid !== 4'b0000 || got != 2) begin errors++;
      $display("FAIL t4_done busy=%0b rd_rdy=%0b rd_vld=%b beats=%0d expected 0/0/0000/2", busy, mem_rd_ready, c_rd_valid, got); end
    clear_inputs();
  endtask

  task automatic test_long_burst();
    bit ok;
    int n = 0;
    @(negedge clock);
    set_req(1, 1'b0, 255, 64'h4000);
    wait_req(ok);
    checks++; if (!ok || grant_id !== 2'd1 || mem_req_len !== 8'hFF) begin errors++;
      $display("FAIL t5_issue ok=%0b grant=%0d len=%0d expected 1/1/255", ok, grant_id, mem_req_len); end
    c_req_valid[1] = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clock);
      mem_rd_valid = 1'b1; c_rd_ready = 4'b0010; mem_rd_bits = 64'(n);
      #1;
      if (busy !== 1'b1) break;
      if (c_rd_valid[1] && mem_rd_ready) n++;
    end
    mem_rd_valid = 1'b0;
    checks++; if (n != 256 || busy !== 1'b0) begin errors++;
      $display("FAIL t5_beats counted=%0d busy=%0b expected 256/0", n, busy); end
    clear_inputs();
  endtask

  task automatic test_reset_mid_write();
    bit ok;
    int pulses = 0;
    @(negedge clock);
    set_req(0, 1'b1, 3, 64'h5000);
    wait_req(ok);
    checks++; if (!ok || grant_id !== 2'd0 || mem_req_opcode !== 1'b1) begin errors++;
      $display("FAIL t6_issue ok=%0b grant=%0d op=%0b expected 1/0/1", ok, grant_id, mem_req_opcode); end
    c_req_valid[0] = 1'b0;
    @(negedge clock);
    c_wr_valid[0] = 1'b1; c_wr_bits[0 +: DB] = 64'h11;
    @(negedge clock);
    c_wr_bits[0 +: DB] = 64'h22;
    #1;
    checks++; if (mem_wr_valid !== 1'b1 || mem_wr_bits !== 64'h22 || busy !== 1'b1) begin errors++;
      $display("FAIL t6_beat2 wr_vld=%0b bits=%h busy=%0b expected 1/22/1", mem_wr_valid, mem_wr_bits, busy); end
    #1 reset_n = 1'b0;
    #1;
    checks++; if ({busy, mem_wr_valid, mem_req_valid, mem_rd_ready} !== 4'b0 || grant_id !== 2'd0 || {c_wr_ready, c_req_ready, c_rd_valid} !== 12'h0 || mem_wr_bits !== 64'h0) begin errors++;
      $display("FAIL t6_async busy=%0b wr_vld=%0b req=%0b grant=%0d wr_rdy=%b bits=%h expected all 0", busy, mem_wr_valid, mem_req_valid, grant_id, c_wr_ready, mem_wr_bits); end
    set_req(3, 1'b0, 0, 64'h7777);
    repeat (2) @(negedge clock);
    #1;
    checks++; if (busy !== 1'b0 || mem_req_valid !== 1'b0 || mem_wr_valid !== 1'b0) begin errors++;
      $display("FAIL t6_held busy=%0b req=%0b wr_vld=%0b expected 0/0/0", busy, mem_req_valid, mem_wr_valid); end
    clear_inputs();
    set_req(1, 1'b0, 0, 64'h6000);
    set_req(3, 1'b0, 0, 64'h7000);
    reset_n = 1'b1;
    wait_req(ok);
    checks++; if (!ok || grant_id !== 2'd1 || mem_req_addr !== 64'h6000 || c_req_ready !== 4'b0010) begin errors++;
      $display("FAIL t6_regrant ok=%0b grant=%0d addr=%h req_rdy=%b expected 1/1/6000/0010", ok, grant_id, mem_req_addr, c_req_ready); end
    // ch3 withdraws before it is granted, so nothing further may be issued.
    c_req_valid = '0;
    @(negedge clock);
    mem_rd_valid = 1'b1; c_rd_ready = 4'b1111;
    #1;
    checks++; if (mem_req_valid !== 1'b0 || c_rd_valid !== 4'b0010) begin errors++;
      $display("FAIL t6_pulse req=%0b rd_vld=%b expected 0/0010", mem_req_valid, c_rd_valid); end
    @(negedge clock);
    mem_rd_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock); #1;
      if (mem_req_valid === 1'b1 || busy === 1'b1) pulses++;
    end
    checks++; if (pulses != 0) begin errors++;
      $display("FAIL t6_dropped_req active_cycles=%0d expected 0", pulses); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_gaps();
    test_rd_backpressure();
    test_long_burst();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
